// File: rtl/fp_mult_pipe_if.sv
// Handshake and operand/result bundle for the pipelined floating-point multiplier.
// master = producer/consumer side, slave = multiplier side.
interface fp_mult_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = EXP_W + MAN_W + 1;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         flag_overflow;
   logic         flag_underflow;
   logic         flag_invalid;
   logic         flag_inexact;

   modport master (
      output in_valid, operand_a, operand_b, out_ready,
      input  in_ready, out_valid, result,
             flag_overflow, flag_underflow, flag_invalid, flag_inexact
   );

   modport slave (
      input  in_valid, operand_a, operand_b, out_ready,
      output in_ready, out_valid, result,
             flag_overflow, flag_underflow, flag_invalid, flag_inexact
   );
endinterface

// File: rtl/fp_mult_pipe.sv
// 3-stage pipelined floating-point multiplier: decode, mantissa multiply, normalise/round.
// Round-to-nearest-even, denormals flushed to zero, whole pipe holds on output stall.
module fp_mult_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic         clk,
   input  logic         rst_n,
   fp_mult_pipe_if.slave bus
);
   localparam int W    = EXP_W + MAN_W + 1;
   localparam int EW   = EXP_W + 2;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;

   localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);
   localparam logic signed [EW-1:0] EXP_ALL1 = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;

   typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

   logic stall, advance;
   assign stall        = bus.out_valid & ~bus.out_ready;
   assign advance      = ~stall;
   assign bus.in_ready = ~stall;

   // ---------------- S1: decode ----------------
   logic                 sa, sb;
   logic [EXP_W-1:0]     ea, eb;
   logic [MAN_W-1:0]     fa, fb;
   logic                 a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   cls_e                 cls1_d;
   logic signed [EW-1:0] exp1_d;

   assign {sa, ea, fa} = bus.operand_a;
   assign {sb, eb, fb} = bus.operand_b;

   always_comb begin
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == '1) && (fa == '0);
      b_inf  = (eb == '1) && (fb == '0);
      a_nan  = (ea == '1) && (fa != '0);
      b_nan  = (eb == '1) && (fb != '0);
      exp1_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
         cls1_d = CLS_NAN;
      else if (a_inf || b_inf)
         cls1_d = CLS_INF;
      else if (a_zero || b_zero)
         cls1_d = CLS_ZERO;
      else
         cls1_d = CLS_NORM;
   end

   logic                 v1_q, sign1_q;
   logic signed [EW-1:0] exp1_q;
   logic [MAN_W:0]       ma1_q, mb1_q;
   cls_e                 cls1_q;

   // ---------------- S2: multiply ----------------
   logic                 v2_q, sign2_q;
   logic signed [EW-1:0] exp2_q;
   logic [PW-1:0]        prod2_q;
   cls_e                 cls2_q;

   // ---------------- S3: normalise, round, special values ----------------
   logic [PW-2:0]        norm;
   logic signed [EW-1:0] exp_n, exp_f;
   logic [MAN_W-1:0]     frac, frac_r;
   logic                 guard, sticky, rnd_up, carry;
   logic [W-1:0]         result_d;
   logic [3:0]           flags_d;   // {overflow, underflow, invalid, inexact}

   always_comb begin
      // Leading one lands in bit PW-1 or PW-2; align it just above the kept fraction.
      norm   = prod2_q[PW-1] ? prod2_q[PW-2:0] : {prod2_q[PW-3:0], 1'b0};
      exp_n  = exp2_q + {{(EW-1){1'b0}}, prod2_q[PW-1]};
      frac   = norm[PW-2 -: MAN_W];
      guard  = norm[MAN_W];
      sticky = |norm[MAN_W-1:0];
      rnd_up = guard & (sticky | frac[0]);
      {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
      exp_f  = exp_n + {{(EW-1){1'b0}}, carry};

      result_d = '0;
      flags_d  = '0;
      unique case (cls2_q)
         CLS_NAN: begin
            result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags_d  = 4'b0010;
         end
         CLS_INF:  result_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         CLS_ZERO: result_d = {sign2_q, {(W-1){1'b0}}};
         default: begin
            if (exp_f >= EXP_ALL1) begin
               result_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags_d  = 4'b1001;
            end else if (exp_f <= EXP_ZERO) begin
               result_d = {sign2_q, {(W-1){1'b0}}};
               flags_d  = 4'b0101;
            end else begin
               result_d = {sign2_q, exp_f[EXP_W-1:0], frac_r};
               flags_d  = {3'b000, guard | sticky};
            end
         end
      endcase
   end

   logic         out_valid_q;
   logic [W-1:0] result_q;
   logic [3:0]   flags_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         sign1_q     <= 1'b0;
         exp1_q      <= '0;
         ma1_q       <= '0;
         mb1_q       <= '0;
         cls1_q      <= CLS_NORM;
         v2_q        <= 1'b0;
         sign2_q     <= 1'b0;
         exp2_q      <= '0;
         prod2_q     <= '0;
         cls2_q      <= CLS_NORM;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else if (advance) begin
         v1_q        <= bus.in_valid;
         sign1_q     <= sa ^ sb;
         exp1_q      <= exp1_d;
         ma1_q       <= {1'b1, fa};
         mb1_q       <= {1'b1, fb};
         cls1_q      <= cls1_d;
         v2_q        <= v1_q;
         sign2_q     <= sign1_q;
         exp2_q      <= exp1_q;
         prod2_q     <= ma1_q * mb1_q;
         cls2_q      <= cls1_q;
         out_valid_q <= v2_q;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   assign bus.out_valid      = out_valid_q;
   assign bus.result         = result_q;
   assign bus.flag_overflow  = flags_q[3];
   assign bus.flag_underflow = flags_q[2];
   assign bus.flag_invalid   = flags_q[1];
   assign bus.flag_inexact   = flags_q[0];
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed scoreboard bench for fp_mult_pipe (single and half precision instances).
module tb_fp_mult_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_mult_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();
   fp_mult_pipe_if #(.EXP_W(5), .MAN_W(10)) bus_h ();

   fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
   fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
      .clk(clk), .rst_n(rst_n), .bus(bus_h.slave));

   localparam logic [3:0] F_OVF = 4'b1000, F_UNF = 4'b0100, F_INV = 4'b0010, F_INX = 4'b0001;

   int n_total = 0;
   int n_pass  = 0;
   int n_out32 = 0;
   int n_out16 = 0;
   logic [35:0] q32[$];
   logic [19:0] q16[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [3:0] flags32();
      return {bus.flag_overflow, bus.flag_underflow, bus.flag_invalid, bus.flag_inexact};
   endfunction

   function automatic logic [3:0] flags16();
      return {bus_h.flag_overflow, bus_h.flag_underflow, bus_h.flag_invalid, bus_h.flag_inexact};
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         n_out32++;
         if (q32.size() == 0) chk("unexpected32", q32.size(), 1);
         else chk("res32", {bus.result, flags32()}, q32.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus_h.out_valid && bus_h.out_ready) begin
         n_out16++;
         if (q16.size() == 0) chk("unexpected16", q16.size(), 1);
         else chk("res16", {bus_h.result, flags16()}, q16.pop_front());
      end
   end

   task automatic send32(input logic [31:0] a, b, r, input logic [3:0] f);
      bit acc = 1'b0;
      bus.in_valid  = 1'b1;
      bus.operand_a = a;
      bus.operand_b = b;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      chk("accept32", acc, 1'b1);
      if (acc) q32.push_back({r, f});
   endtask

   task automatic send16(input logic [15:0] a, b, r, input logic [3:0] f);
      bit acc = 1'b0;
      bus_h.in_valid  = 1'b1;
      bus_h.operand_a = a;
      bus_h.operand_b = b;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = bus_h.in_ready;
         @(posedge clk);
         #1;
      end
      bus_h.in_valid = 1'b0;
      chk("accept16", acc, 1'b1);
      if (acc) q16.push_back({r, f});
   endtask

   // Called right after send32 returns (acceptance edge counts as cycle 1).
   task automatic latency32(input string tag);
      int lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk(tag, lat, 3);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (q32.size() != 0 || q16.size() != 0); i++) @(posedge clk);
      #1;
      chk("drain32", q32.size(), 0);
      chk("drain16", q16.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      logic [35:0] held;
      bus.in_valid = 1'b0;  bus.operand_a = '0; bus.operand_b = '0; bus.out_ready = 1'b1;
      bus_h.in_valid = 1'b0; bus_h.operand_a = '0; bus_h.operand_b = '0; bus_h.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_result", bus.result, 32'h0);
      chk("rst_flags", flags32(), 4'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1'b1);

      send32(32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0);
      latency32("latency_basic");
      drain();

      send32(32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0);
      send32(32'h3F800001, 32'h3F800001, 32'h3F800002, F_INX);
      send32(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, F_INX);
      send32(32'h7F000000, 32'h40000000, 32'h7F800000, F_OVF | F_INX);
      send32(32'h00800000, 32'h3F000000, 32'h00000000, F_UNF | F_INX);
      send32(32'h00000000, 32'h7F800000, 32'h7FC00000, F_INV);
      send32(32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0);
      send32(32'h7FC00001, 32'h3F800000, 32'h7FC00000, F_INV);
      send32(32'h80000000, 32'h40400000, 32'h80000000, 4'h0);
      send16(16'h3E00, 16'h4000, 16'h4200, 4'h0);
      send16(16'h7800, 16'h4000, 16'h7C00, F_OVF | F_INX);
      drain();

      n0 = n_out32;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send32(32'h3F800000 | (32'(i) << 20), 32'h40000000,
                      32'h40000000 | (32'(i) << 20), 4'h0);
         end
         begin
            repeat (3) @(posedge clk);
            #2;
            bus.out_ready = 1'b0;
            @(negedge clk);
            held = {bus.result, flags32()};
            chk("stall_in_ready", bus.in_ready, 1'b0);
            repeat (4) begin
               @(negedge clk);
               chk("stall_in_ready", bus.in_ready, 1'b0);
               chk("stall_hold", {bus.result, flags32()}, held);
            end
            @(posedge clk);
            #2;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count", n_out32 - n0, 6);

      n0 = n_out32;
      send32(32'h3F800000, 32'h40400000, 32'h40400000, 4'h0);
      send32(32'h3F800000, 32'h40800000, 32'h40800000, 4'h0);
      send32(32'h3F800000, 32'h40A00000, 32'h40A00000, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_out_valid", bus.out_valid, 1'b0);
      q32.delete();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_no_ghost", n_out32 - n0, 0);
      send32(32'h40000000, 32'h40000000, 32'h40800000, 4'h0);
      latency32("latency_after_rst");
      drain();
      chk("rst_one_out", n_out32 - n0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
